// File: rtl/audio_uart_tx_pkg.sv
// Shared constants, FSM state type and width helper for the audio UART transmitter.
package audio_uart_tx_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_uart_tx_if.sv
// Valid/ready byte-source handshake between the sample formatter and the UART transmitter.
interface audio_uart_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready
  );

endinterface

// File: rtl/audio_uart_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit to tell full from empty.
module audio_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // Empty is taken from registered pointers, so a word pushed this cycle cannot be popped this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/audio_uart_tx.sv
// UART transmitter: input FIFO, per-state baud counter, optional parity, 1 or 2 stop bits.
module audio_uart_tx
  import audio_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  audio_uart_tx_if.slave              src,
  output logic                        o_serial,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int BAUD_W = cnt_w(CLKS_PER_BIT);
  localparam int BIT_W  = cnt_w(DATA_W);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              serial_q, serial_d;
  logic              busy_q, busy_d;
  logic              rdy_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              bit_end;
  logic              load;

  assign src.o_ready = rdy_q & ~fifo_full;
  assign fifo_push   = src.i_valid & src.o_ready;

  audio_uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .push_i  (fifo_push),
    .data_i  (src.i_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_fifo_level)
  );

  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    load     = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            // Chaining straight into the next START keeps frames gap-free.
            if (!fifo_empty) load = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
      par_d    = (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
      baud_d   = '0;
      bit_d    = '0;
      state_d  = ST_START;
    end
  end

  // The line level is computed from the next state so o_serial comes straight from a flop.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[0];
      ST_PARITY: serial_d = par_d;
      default:   serial_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      rdy_q    <= 1'b1;
    end
  end

  assign o_serial = serial_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_audio_uart_tx.sv
// Directed bench for audio_uart_tx: four parameter sets, frame table plus burst and reset sequences.
module tb_audio_uart_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  audio_uart_tx_if #(.DATA_W(8)) if0 ();
  audio_uart_tx_if #(.DATA_W(8)) if1 ();
  audio_uart_tx_if #(.DATA_W(8)) if2 ();
  audio_uart_tx_if #(.DATA_W(9)) if3 ();

  logic       ser  [4];
  logic       busy [4];
  logic [2:0] lvl  [4];

  // 8N1
  audio_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .src(if0), .o_serial(ser[0]), .o_busy(busy[0]), .o_fifo_level(lvl[0]));
  // 8E2
  audio_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .src(if1), .o_serial(ser[1]), .o_busy(busy[1]), .o_fifo_level(lvl[1]));
  // 8O1
  audio_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .src(if2), .o_serial(ser[2]), .o_busy(busy[2]), .o_fifo_level(lvl[2]));
  // 9N2 at two clocks per bit
  audio_uart_tx #(.CLKS_PER_BIT(2), .DATA_W(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .i_clk(clk), .i_rst(rst_n), .src(if3), .o_serial(ser[3]), .o_busy(busy[3]), .o_fifo_level(lvl[3]));

  typedef struct {
    int         dut;
    logic [8:0] word;
    int         nbits;
    int         cpb;
    logic [15:0] frame;   // line level of each bit period, start bit at [0]
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] burst_w [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [8:0] w);
    case (d)
      0:       begin if0.i_valid = v; if0.i_data = w[7:0]; end
      1:       begin if1.i_valid = v; if1.i_data = w[7:0]; end
      2:       begin if2.i_valid = v; if2.i_data = w[7:0]; end
      default: begin if3.i_valid = v; if3.i_data = w;      end
    endcase
  endtask

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return if0.o_ready;
      1:       return if1.o_ready;
      2:       return if2.o_ready;
      default: return if3.o_ready;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 9'h0A5, 10, 4, 16'({1'b1, 8'hA5, 1'b0})};
    vecs[1] = '{0, 9'h03C, 10, 4, 16'({1'b1, 8'h3C, 1'b0})};
    vecs[2] = '{1, 9'h007, 12, 4, 16'({2'b11, 1'b1, 8'h07, 1'b0})};
    vecs[3] = '{1, 9'h003, 12, 4, 16'({2'b11, 1'b0, 8'h03, 1'b0})};
    vecs[4] = '{2, 9'h007, 11, 4, 16'({1'b1, 1'b0, 8'h07, 1'b0})};
    vecs[5] = '{2, 9'h000, 11, 4, 16'({1'b1, 1'b1, 8'h00, 1'b0})};
    vecs[6] = '{3, 9'h1FF, 12, 2, 16'({2'b11, 9'h1FF, 1'b0})};
    vecs[7] = '{3, 9'h0AA, 12, 2, 16'({2'b11, 9'h0AA, 1'b0})};
    burst_w = '{8'h11, 8'h22, 8'h5A, 8'hC3, 8'hF0, 8'h99};

    for (int d = 0; d < 4; d++) drive(d, 1'b0, 9'h000);
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_serial%0d", d), 32'(ser[d]), 32'd1);
      chk($sformatf("rst_ready%0d", d), 32'(rdy_of(d)), 32'd0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_level%0d", d), 32'(lvl[d]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(rdy_of(0)), 32'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) chk($sformatf("ready_after_release%0d", d), 32'(rdy_of(d)), 32'd1);

    // Single frames, every cycle of the frame compared
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].dut, 1'b1, vecs[i].word);
      @(posedge clk);
      #1;
      drive(vecs[i].dut, 1'b0, ~vecs[i].word);
      chk($sformatf("v%0d_line_at_accept", i), 32'(ser[vecs[i].dut]), 32'd1);
      for (int c = 0; c < vecs[i].nbits * vecs[i].cpb; c++) begin
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_line_c%0d", i, c), 32'(ser[vecs[i].dut]), 32'(vecs[i].frame[c / vecs[i].cpb]));
        chk($sformatf("v%0d_busy_c%0d", i, c), 32'(busy[vecs[i].dut]), 32'd1);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_line", i), 32'(ser[vecs[i].dut]), 32'd1);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy[vecs[i].dut]), 32'd0);
      chk($sformatf("v%0d_idle_level", i), 32'(lvl[vecs[i].dut]), 32'd0);
    end

    // Burst: valid held 16 cycles, sixth word refused while full, five frames back-to-back
    for (int n = 1; n <= 205; n++) begin
      if (n <= 16) drive(0, 1'b1, {1'b0, (n <= 5) ? burst_w[n-1] : burst_w[5]});
      else         drive(0, 1'b0, 9'h000);
      @(posedge clk);
      #1;
      if (n <= 16) begin
        chk($sformatf("burst_level_n%0d", n), 32'(lvl[0]), (n <= 2) ? 32'd1 : ((n >= 5) ? 32'd4 : 32'(n - 1)));
        chk($sformatf("burst_ready_n%0d", n), 32'(if0.o_ready), (n <= 4) ? 32'd1 : 32'd0);
      end
      if (n >= 2 && n <= 201) begin
        int         k;
        logic [9:0] fr;
        k  = n - 2;
        fr = {1'b1, burst_w[k / 40], 1'b0};
        chk($sformatf("burst_line_n%0d", n), 32'(ser[0]), 32'(fr[(k / 4) % 10]));
        chk($sformatf("burst_busy_n%0d", n), 32'(busy[0]), 32'd1);
      end else begin
        chk($sformatf("burst_idle_line_n%0d", n), 32'(ser[0]), 32'd1);
        chk($sformatf("burst_idle_busy_n%0d", n), 32'(busy[0]), 32'd0);
        if (n >= 202) chk($sformatf("burst_idle_level_n%0d", n), 32'(lvl[0]), 32'd0);
      end
    end

    // Reset during data bit 3 of 0x52 (line low) with two words queued
    drive(0, 1'b1, 9'h052);
    @(posedge clk); #1;
    drive(0, 1'b1, 9'h06B);
    @(posedge clk); #1;
    drive(0, 1'b1, 9'h07C);
    @(posedge clk); #1;
    drive(0, 1'b0, 9'h000);
    repeat (15) @(posedge clk);
    #1;
    chk("pre_reset_line", 32'(ser[0]), 32'd0);
    chk("pre_reset_level", 32'(lvl[0]), 32'd2);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_line", 32'(ser[0]), 32'd1);
    chk("abort_level", 32'(lvl[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_ready", 32'(if0.o_ready), 32'd0);
    #3 rst_n = 1'b1;
    #1;
    chk("release_ready_before_edge", 32'(if0.o_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("release_ready", 32'(if0.o_ready), 32'd1);
    chk("release_level", 32'(lvl[0]), 32'd0);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_line_c%0d", c), 32'(ser[0]), 32'd1);
      chk($sformatf("post_reset_busy_c%0d", c), 32'(busy[0]), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
